// File: rtl/mono_pkg.sv
// Shared constants and types for the mono data path (rx FIFOs and merge).
package mono_pkg;

  // Width of one data word on every mono stream.
  localparam int MONO_WORD_W = 32;

  // Default maximum number of words taken from one source per grant.
  localparam int MONO_BURST_LEN = 16;

  typedef logic [MONO_WORD_W-1:0] mono_word_t;

endpackage

// File: rtl/mono_merge_obuf.sv
// Two-entry first-word-fall-through output buffer for the merged stream.
// Head register always holds the oldest word so the read path is a plain flop.
module mono_merge_obuf
  import mono_pkg::*;
(
  input  logic       BUS_CLK,
  input  logic       BUS_RST_N,
  input  logic       i_push,
  input  mono_word_t i_data,
  input  logic       i_pop,
  output logic       o_empty,
  output logic       o_full,
  output mono_word_t o_data
);

  mono_word_t r_head;
  mono_word_t r_tail;
  logic [1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_empty = (r_count == 2'd0);
  assign o_full  = (r_count == 2'd2);
  assign o_data  = r_head;

  // A pop of an empty buffer is ignored; a push into a full buffer is dropped.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & ~o_full;

  // Buffer storage and occupancy; head is oldest, tail is second-oldest.
  always_ff @(posedge BUS_CLK) begin
    // NOTE: the two data entries are reset as well, so OUT_DATA reads 0 after reset instead of stale data.
    if (!BUS_RST_N) begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values regardless of statement order.
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= i_data;
          else                 r_tail <= i_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new word lands behind whatever remains.
          if (r_count == 2'd1) begin
            r_head <= i_data;
          end else begin
            r_head <= r_tail;
            r_tail <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mono_data_merge.sv
// Round-robin merge of N_SRC first-word-fall-through FIFOs into one stream.
// A grant holds a source for up to BURST_LEN words; switching costs one IDLE cycle.
module mono_data_merge
  import mono_pkg::*;
#(
  parameter int N_SRC     = 4,
  parameter int BURST_LEN = MONO_BURST_LEN
)(
  input  logic                         BUS_CLK,
  input  logic                         BUS_RST_N,
  input  logic [N_SRC-1:0]             SRC_ENABLE,
  input  logic [N_SRC-1:0]             SRC_EMPTY,
  input  logic [MONO_WORD_W*N_SRC-1:0] SRC_DATA,
  output logic [N_SRC-1:0]             SRC_READ,
  input  logic                         OUT_READ,
  output logic                         OUT_EMPTY,
  output mono_word_t                   OUT_DATA,
  output logic [31:0]                  WORD_CNT
);

  localparam int GW = $clog2(N_SRC);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  localparam logic [7:0] LAST_CNT = 8'(BURST_LEN - 1);

  logic [0:0]    r_state;
  logic [GW-1:0] r_grant;
  logic [7:0]    r_burst_cnt;
  logic [31:0]   r_word_cnt;

  mono_word_t    w_src_word [N_SRC];
  logic          w_found;
  logic [GW-1:0] w_sel;
  logic          w_src_ok;
  logic          w_obuf_full;
  logic          w_out_empty;
  logic          w_pop;
  logic          w_out_pop;
  logic [31:0]   w_word_cnt_nxt;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src_word
    assign w_src_word[g] = SRC_DATA[MONO_WORD_W*g +: MONO_WORD_W];
  end

  // Round-robin pick: first ready source after the last grant, wrapping to itself last.
  always_comb begin
    logic [GW-1:0] cand;
    // NOTE: defaults before any conditional write keep this block free of inferred latches.
    w_found = 1'b0;
    w_sel   = r_grant;
    cand    = '0;
    // Walk offsets high to low so the smallest offset is the one that sticks.
    for (int k = N_SRC; k >= 1; k--) begin
      cand = GW'((int'(r_grant) + k) % N_SRC);
      if (SRC_ENABLE[cand] && !SRC_EMPTY[cand]) begin
        w_found = 1'b1;
        w_sel   = cand;
      end
    end
  end

  assign w_src_ok  = SRC_ENABLE[r_grant] & ~SRC_EMPTY[r_grant];
  // Reset is folded in so no pop escapes during the reset cycle.
  assign w_pop     = BUS_RST_N & (r_state == S_BURST) & w_src_ok & ~w_obuf_full;
  assign w_out_pop = OUT_READ & ~w_out_empty;
  assign OUT_EMPTY = w_out_empty;

  // Pop strobe goes only to the granted source.
  always_comb begin
    SRC_READ = '0;
    if (w_pop) SRC_READ[r_grant] = 1'b1;
  end

  // Arbitration FSM: IDLE picks a source, BURST drains it until limit, empty or disable.
  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST_N) begin
      r_state     <= S_IDLE;
      r_grant     <= GW'(N_SRC - 1);
      r_burst_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant     <= w_sel;
            r_burst_cnt <= '0;
            r_state     <= S_BURST;
          end
        end
        S_BURST: begin
          if (!w_src_ok) begin
            r_state <= S_IDLE;
          end else if (w_pop) begin
            if (r_burst_cnt == LAST_CNT) r_state <= S_IDLE;
            else                         r_burst_cnt <= r_burst_cnt + 8'd1;
          end
          // A full output buffer leaves both state and count untouched.
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_word_cnt_nxt = w_out_pop ? r_word_cnt + 32'd1 : r_word_cnt;

  // Delivered-word counter; wraps naturally at 2^32.
  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST_N) r_word_cnt <= '0;
    else            r_word_cnt <= w_word_cnt_nxt;
  end

  assign WORD_CNT = r_word_cnt;

  mono_merge_obuf u_obuf (
    .BUS_CLK   (BUS_CLK),
    .BUS_RST_N (BUS_RST_N),
    .i_push    (w_pop),
    .i_data    (w_src_word[r_grant]),
    .i_pop     (w_out_pop),
    .o_empty   (w_out_empty),
    .o_full    (w_obuf_full),
    .o_data    (OUT_DATA)
  );

endmodule
